// File: rtl/pc_stack_pkg.sv
// Shared types and helpers for the program counter with return-address stack.
package pc_stack_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_LOAD,
    OP_CALL,
    OP_RET,
    OP_CLR
  } pc_op_e;

  // Width of a stack-depth count that must represent 0..d inclusive.
  function automatic int unsigned depth_w(input int unsigned d);
    return 32'($clog2(d)) + 32'd1;
  endfunction

  // One operation per cycle; clr beats the stall, ret beats call.
  function automatic pc_op_e op_decode(input logic clr, input logic en, input logic ret,
                                       input logic call, input logic load, input logic inc);
    if (clr)       return OP_CLR;
    else if (!en)  return OP_HOLD;
    else if (ret)  return OP_RET;
    else if (call) return OP_CALL;
    else if (load) return OP_LOAD;
    else if (inc)  return OP_INC;
    else           return OP_HOLD;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// WIDTH x DEPTH return-address LIFO; a push while full or a pop while empty is ignored.
module ret_stack
  import pc_stack_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned DW    = depth_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    sp;
  logic [AW-1:0]    top_idx;
  logic             do_push;
  logic             do_pop;

  assign full    = (sp == DW'(DEPTH));
  assign empty   = (sp == '0);
  assign depth   = sp;
  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && !full && !pop && !clr;

  // Entry below the stack pointer; wraps harmlessly when empty.
  assign top_idx = sp[AW-1:0] - AW'(1);
  assign top     = mem[top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (clr) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + DW'(1);
    end else if (do_pop) begin
      sp <= sp - DW'(1);
    end
  end

  // Storage needs no reset: entries above sp are never read as valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[sp[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with hardware return-address stack.
// Define PC_STACK_TRAP_EN to redirect stack faults to TRAP_VEC with a one-cycle trap pulse.
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter  int unsigned      WIDTH     = 16,
  parameter  int unsigned      DEPTH     = 8,
  parameter  logic [WIDTH-1:0] RESET_VEC = '0,
  parameter  logic [WIDTH-1:0] TRAP_VEC  = WIDTH'('h0010),
  localparam int unsigned      DW        = depth_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] load_addr,
  input  logic             call,
  input  logic [WIDTH-1:0] call_addr,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty,
  output logic             ovf_err,
  output logic             unf_err,
  output logic             trap
);

`ifdef PC_STACK_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  pc_op_e           op;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] top;
  logic             ovf_d;
  logic             unf_d;
  logic             trap_d;
  logic             push;
  logic             pop;

  assign op     = op_decode(clr, en, ret, call, load, inc);
  assign pc_inc = pc + WIDTH'(1);

  ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (op == OP_CLR),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (top),
    .depth     (depth),
    .full      (full),
    .empty     (empty)
  );

  // Next PC, stack control and fault handling for the selected op.
  always_comb begin
    pc_d   = pc;
    ovf_d  = ovf_err;
    unf_d  = unf_err;
    trap_d = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    unique case (op)
      OP_CLR: begin
        pc_d  = RESET_VEC;
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      OP_RET: begin
        if (empty) begin
          unf_d = 1'b1;
          if (TRAP_EN) begin
            pc_d   = TRAP_VEC;
            trap_d = 1'b1;
          end
        end else begin
          pc_d = top;
          pop  = 1'b1;
        end
      end
      OP_CALL: begin
        if (full) begin
          ovf_d = 1'b1;
          if (TRAP_EN) begin
            pc_d   = TRAP_VEC;
            trap_d = 1'b1;
          end
        end else begin
          pc_d = call_addr;
          push = 1'b1;
        end
      end
      OP_LOAD: pc_d = load_addr;
      OP_INC:  pc_d = pc_inc;
      default: pc_d = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_VEC;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
      trap    <= 1'b0;
    end else begin
      pc      <= pc_d;
      ovf_err <= ovf_d;
      unf_err <= unf_d;
      trap    <= trap_d;
    end
  end

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed scenarios plus randomized ops against a queue-based model.
module tb_pc_stack;

  localparam int unsigned   W  = 16;
  localparam int unsigned   D  = 8;
  localparam logic [W-1:0]  RV = 16'h0000;
  localparam logic [W-1:0]  TV = 16'h0010;
`ifdef PC_STACK_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, clr, inc, load, call, ret;
  logic [W-1:0] load_addr, call_addr;
  logic [W-1:0] pc;
  logic [3:0]   depth;
  logic         full, empty, ovf_err, unf_err, trap;

  logic         s_en, s_clr, s_inc, s_load, s_call, s_ret;
  logic [3:0]   s_la, s_ca;
  logic [3:0]   s_pc;
  logic [1:0]   s_depth;
  logic         s_full, s_empty, s_ovf, s_unf, s_trap;

  int errors = 0;
  int checks = 0;

  // Reference model: PC value, LIFO of return addresses, sticky flags.
  logic [W-1:0] m_pc;
  logic [W-1:0] m_q [$];
  logic         m_ovf, m_unf, m_trap;

  always #5 clk = ~clk;

  pc_stack #(.WIDTH(W), .DEPTH(D), .RESET_VEC(RV), .TRAP_VEC(TV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .inc(inc), .load(load),
    .load_addr(load_addr), .call(call), .call_addr(call_addr), .ret(ret),
    .pc(pc), .depth(depth), .full(full), .empty(empty),
    .ovf_err(ovf_err), .unf_err(unf_err), .trap(trap)
  );

  pc_stack #(.WIDTH(4), .DEPTH(2), .RESET_VEC(4'h0), .TRAP_VEC(4'h8)) dut_small (
    .clk(clk), .rst_n(rst_n), .en(s_en), .clr(s_clr), .inc(s_inc), .load(s_load),
    .load_addr(s_la), .call(s_call), .call_addr(s_ca), .ret(s_ret),
    .pc(s_pc), .depth(s_depth), .full(s_full), .empty(s_empty),
    .ovf_err(s_ovf), .unf_err(s_unf), .trap(s_trap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RV;
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_trap = 1'b0;
  endtask

  task automatic model_step();
    m_trap = 1'b0;
    if (clr) begin
      m_pc = RV;
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!en) begin
      // stalled
    end else if (ret) begin
      if (m_q.size() > 0) begin
        m_pc = m_q.pop_back();
      end else begin
        m_unf = 1'b1;
        if (TRAP_ON) begin m_pc = TV; m_trap = 1'b1; end
      end
    end else if (call) begin
      if (m_q.size() == D) begin
        m_ovf = 1'b1;
        if (TRAP_ON) begin m_pc = TV; m_trap = 1'b1; end
      end else begin
        m_q.push_back(W'((32'(m_pc) + 1) % 65536));
        m_pc = call_addr;
      end
    end else if (load) begin
      m_pc = load_addr;
    end else if (inc) begin
      m_pc = W'((32'(m_pc) + 1) % 65536);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    32'(pc),      32'(m_pc));
    check({tag, ".depth"}, 32'(depth),   32'(m_q.size()));
    check({tag, ".full"},  32'(full),    32'(m_q.size() == D));
    check({tag, ".empty"}, 32'(empty),   32'(m_q.size() == 0));
    check({tag, ".ovf"},   32'(ovf_err), 32'(m_ovf));
    check({tag, ".unf"},   32'(unf_err), 32'(m_unf));
    check({tag, ".trap"},  32'(trap),    32'(m_trap));
  endtask

  task automatic drive(input logic e, input logic c, input logic r, input logic ca,
                       input logic l, input logic i, input logic [W-1:0] la,
                       input logic [W-1:0] cad);
    en = e; clr = c; ret = r; call = ca; load = l; inc = i;
    load_addr = la; call_addr = cad;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    s_en = 1'b0; s_clr = 1'b0; s_inc = 1'b0; s_load = 1'b0;
    s_call = 1'b0; s_ret = 1'b0; s_la = '0; s_ca = '0;
    model_reset();
    #2;
    check_all("reset");
    #10;
    rst_n = 1'b1;

    // Narrow PC wraps; a stall blocks a load.
    s_en = 1'b1; s_inc = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    check("w4.pc15", 32'(s_pc), 32'd15);
    @(posedge clk); #1;
    check("w4.wrap", 32'(s_pc), 32'd0);
    s_en = 1'b0; s_inc = 1'b0; s_load = 1'b1; s_la = 4'd7;
    @(posedge clk); #1;
    check("w4.stall", 32'(s_pc), 32'd0);
    s_load = 1'b0;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    repeat (3) tick("inc");
    check("inc3.pc", 32'(pc), 32'd3);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5, '0);
    tick("load5");
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 16'h0100);
    tick("call100");
    check("call100.pc", 32'(pc), 32'h100);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick("ret1");
    check("ret1.pc", 32'(pc), 32'd6);

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, W'(16'h0200 + 16'(i) * 16'h0010));
      tick("nest");
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 16'h0abc);
    tick("call9");
    check("call9.ovf", 32'(ovf_err), 32'd1);
    check("call9.pc", 32'(pc), TRAP_ON ? 32'(TV) : 32'h0270);
    check("call9.trap", 32'(trap), 32'(TRAP_ON));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick("post9");
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      tick("unwind");
    end
    check("unwind.last", 32'(pc), 32'd7);

    tick("ret_empty");
    check("ret_empty.unf", 32'(unf_err), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick("clr");

    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 16'h0300);
    tick("c2a");
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 16'h0400);
    tick("c2b");
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 16'h0500);
    tick("callret");
    check("callret.pc", 32'(pc), 32'h301);

    // Asynchronous reset mid call sequence, observed before the next edge.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 16'h0600);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    rst_n = 1'b1;

    for (int n = 0; n < 500; n++) begin
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 40),
            ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 50),
            W'($urandom), W'($urandom));
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
